led_panel_scanner: RTL and testbench

- Frame-buffer-to-panel scan sequencer for the cube's LED driver chains on the GPIO headers.
- Each row is read from an external frame-buffer RAM with 1-cycle read latency, one bit-plane at a time.
- Each bit-plane is serialised into the driver shift-register chain, latched, and displayed for a binary-weighted time (bit-angle modulation).
- Sits between the frame-buffer memory and the GPIO pin drivers in cube_controller.

---
 rtl/led_panel_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_led_panel_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_scanner.sv
// Row/bit-plane scan sequencer: fetches pixels from the frame buffer, shifts one
// bit-plane into the LED driver chain, latches it and shows it for a binary-weighted time.
module led_panel_scanner #(
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned BITS       = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned BASE_TICKS = 8
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            fb_rd,
  output logic [$clog2(ROWS*COLS)-1:0]    fb_addr,
  input  logic [3*BITS-1:0]               fb_data,
  output logic                            panel_r,
  output logic                            panel_g,
  output logic                            panel_b,
  output logic                            panel_sclk,
  output logic                            panel_latch,
  output logic                            panel_oe_n,
  output logic [$clog2(ROWS)-1:0]         panel_row,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned AW       = $clog2(ROWS*COLS);
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned CLW      = $clog2(COLS);
  localparam int unsigned PW       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned DISP_MAX = BASE_TICKS << (BITS - 1);
  localparam int unsigned CNT_MAX  = (DISP_MAX > CLK_DIV) ? DISP_MAX : CLK_DIV;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fb_rd_q, fb_rd_d;
  logic [AW-1:0]    fb_addr_q, fb_addr_d;
  logic             panel_r_q, panel_r_d;
  logic             panel_g_q, panel_g_d;
  logic             panel_b_q, panel_b_d;
  logic             panel_sclk_q, panel_sclk_d;
  logic             panel_latch_q, panel_latch_d;
  logic             panel_oe_n_q, panel_oe_n_d;
  logic [RW-1:0]    panel_row_q, panel_row_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [BITS-1:0]  r_px, g_px, b_px;
  logic [CW-1:0]    disp_last, disp_last_d;
  logic             shift_last;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    panel_r_d  = panel_r_q;
    panel_g_d  = panel_g_q;
    panel_b_d  = panel_b_q;

    r_px       = fb_data[3*BITS-1 -: BITS];
    g_px       = fb_data[2*BITS-1 -: BITS];
    b_px       = fb_data[BITS-1:0];
    disp_last  = (CW'(BASE_TICKS) << plane_q) - CW'(1);
    shift_last = (cnt_q == CW'(CLK_DIV - 1));

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          plane_d = '0;
        end
      end
      FETCH: begin
        state_d = SHIFT_LO;
        cnt_d   = '0;
      end
      SHIFT_LO: begin
        // RAM data is only valid in the first cycle after the read strobe
        if (cnt_q == '0) begin
          panel_r_d = r_px[plane_q];
          panel_g_d = g_px[plane_q];
          panel_b_d = b_px[plane_q];
        end
        if (shift_last) begin
          state_d = SHIFT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT_HI: begin
        if (shift_last) begin
          cnt_d = '0;
          if (col_q == CLW'(COLS - 1)) begin
            col_d   = '0;
            state_d = LATCH;
          end else begin
            col_d   = col_q + CLW'(1);
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        if (cnt_q == disp_last) begin
          cnt_d = '0;
          if (plane_q != PW'(BITS - 1)) begin
            plane_d = plane_q + PW'(1);
            state_d = FETCH;
          end else begin
            plane_d = '0;
            if (row_q != RW'(ROWS - 1)) begin
              row_d   = row_q + RW'(1);
              state_d = FETCH;
            end else begin
              row_d   = '0;
              state_d = enable ? FETCH : IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q
    disp_last_d   = (CW'(BASE_TICKS) << plane_d) - CW'(1);
    fb_rd_d       = (state_d == FETCH);
    fb_addr_d     = (state_d == FETCH) ? AW'(32'(row_d) * COLS + 32'(col_d)) : fb_addr_q;
    panel_sclk_d  = (state_d == SHIFT_HI);
    panel_latch_d = (state_d == LATCH);
    panel_oe_n_d  = (state_d != DISPLAY);
    panel_row_d   = (state_d == LATCH) ? row_d : panel_row_q;
    busy_d        = (state_d != IDLE);
    frame_done_d  = (state_d == DISPLAY) && (cnt_d == disp_last_d) &&
                    (plane_d == PW'(BITS - 1)) && (row_d == RW'(ROWS - 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      plane_q       <= '0;
      cnt_q         <= '0;
      fb_rd_q       <= 1'b0;
      fb_addr_q     <= '0;
      panel_r_q     <= 1'b0;
      panel_g_q     <= 1'b0;
      panel_b_q     <= 1'b0;
      panel_sclk_q  <= 1'b0;
      panel_latch_q <= 1'b0;
      panel_oe_n_q  <= 1'b1;
      panel_row_q   <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      plane_q       <= plane_d;
      cnt_q         <= cnt_d;
      fb_rd_q       <= fb_rd_d;
      fb_addr_q     <= fb_addr_d;
      panel_r_q     <= panel_r_d;
      panel_g_q     <= panel_g_d;
      panel_b_q     <= panel_b_d;
      panel_sclk_q  <= panel_sclk_d;
      panel_latch_q <= panel_latch_d;
      panel_oe_n_q  <= panel_oe_n_d;
      panel_row_q   <= panel_row_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign fb_rd       = fb_rd_q;
  assign fb_addr     = fb_addr_q;
  assign panel_r     = panel_r_q;
  assign panel_g     = panel_g_q;
  assign panel_b     = panel_b_q;
  assign panel_sclk  = panel_sclk_q;
  assign panel_latch = panel_latch_q;
  assign panel_oe_n  = panel_oe_n_q;
  assign panel_row   = panel_row_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_panel_scanner.sv
// Scoreboard bench for led_panel_scanner: directed frames on a small panel plus
// an invariant run on a second instance with slower shift clock and odd display base.
module tb_led_panel_scanner;

  localparam int COLS = 4, ROWS = 2, BITS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_ev(input string name, input int c);
    checks++;
    $display("FAIL %s: event at cycle %0d, none expected", name, c);
  endtask

  // ---------------- main instance ----------------
  logic       reset, enable;
  logic       fb_rd;
  logic [2:0] fb_addr;
  logic [5:0] fb_data = '0;
  logic       panel_r, panel_g, panel_b, panel_sclk, panel_latch, panel_oe_n;
  logic [0:0] panel_row;
  logic       busy, frame_done;

  led_panel_scanner #(.COLS(4), .ROWS(2), .BITS(2), .CLK_DIV(1), .BASE_TICKS(2)) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
    .panel_sclk(panel_sclk), .panel_latch(panel_latch), .panel_oe_n(panel_oe_n),
    .panel_row(panel_row), .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [5:0] pix(input logic [2:0] a);
    return {a[1:0], ~a[1:0], 2'b01};
  endfunction

  // Model RAM: 1-cycle read latency, junk whenever no read was issued
  always @(posedge clk) fb_data <= fb_rd ? pix(fb_addr) : 6'($urandom);

  typedef struct {int c; int v;} ev_t;
  ev_t q_rd[$];
  ev_t q_latch[$];
  int  q_bit[$];
  int  q_oe[$];
  int  q_done[$];
  bit  mon_en = 1'b0;

  // Expected events of one full frame whose first fetch is at cycle base
  task automatic push_frame(input int base);
    int t = base;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < BITS; p++) begin
        for (int c = 0; c < COLS; c++) begin
          int i = r * COLS + c;
          q_rd.push_back(ev_t'{t + 3 * c, i});
          q_bit.push_back(((i >> p) & 1) * 4 + (((~i) >> p) & 1) * 2 + ((p == 0) ? 1 : 0));
        end
        q_latch.push_back(ev_t'{t + 12, r});
        q_oe.push_back(2 << p);
        t += 13 + (2 << p);
      end
    end
    q_done.push_back(base + 63);
  endtask

  logic       sclk_prev = 1'b0;
  logic [0:0] row_prev = '0;
  int         oe_run = 0;
  ev_t        em;

  always @(negedge clk) begin
    chk("latch_sclk_overlap", int'(panel_latch & panel_sclk), 0);
    if (panel_row != row_prev) chk("row_change_blanked", int'(panel_oe_n), 1);
    if (mon_en) begin
      if (fb_rd) begin
        if (q_rd.size() == 0) fail_ev("rd_unexpected", cyc);
        else begin
          em = q_rd.pop_front();
          chk("rd_cycle", cyc, em.c);
          chk("rd_addr", int'(fb_addr), em.v);
        end
      end
      if (panel_sclk && !sclk_prev) begin
        if (q_bit.size() == 0) fail_ev("sclk_unexpected", cyc);
        else chk("rgb_at_sclk_rise", int'({panel_r, panel_g, panel_b}), q_bit.pop_front());
      end
      if (panel_latch) begin
        if (q_latch.size() == 0) fail_ev("latch_unexpected", cyc);
        else begin
          em = q_latch.pop_front();
          chk("latch_cycle", cyc, em.c);
          chk("latch_row", int'(panel_row), em.v);
        end
      end
      if (!panel_oe_n) oe_run++;
      else if (oe_run > 0) begin
        if (q_oe.size() == 0) fail_ev("oe_unexpected", cyc);
        else chk("oe_low_len", oe_run, q_oe.pop_front());
        oe_run = 0;
      end
      if (frame_done) begin
        if (q_done.size() == 0) fail_ev("done_unexpected", cyc);
        else chk("frame_done_cycle", cyc, q_done.pop_front());
      end
    end else begin
      oe_run = 0;
    end
    sclk_prev = panel_sclk;
    row_prev  = panel_row;
  end

  task automatic check_drained();
    chk("rd_q_drained", q_rd.size(), 0);
    chk("bit_q_drained", q_bit.size(), 0);
    chk("latch_q_drained", q_latch.size(), 0);
    chk("oe_q_drained", q_oe.size(), 0);
    chk("done_q_drained", q_done.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_oe_n"}, int'(panel_oe_n), 1);
    chk({tag, "_fb_rd"}, int'(fb_rd), 0);
    chk({tag, "_fb_addr"}, int'(fb_addr), 0);
    chk({tag, "_rgb"}, int'({panel_r, panel_g, panel_b}), 0);
    chk({tag, "_sclk"}, int'(panel_sclk), 0);
    chk({tag, "_latch"}, int'(panel_latch), 0);
    chk({tag, "_row"}, int'(panel_row), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // ---------------- invariant instance ----------------
  logic        reset2, enable2;
  logic        fb_rd2;
  logic [2:0]  fb_addr2;
  logic [5:0]  fb_data2 = '0;
  logic        r2, g2, b2, sclk2, latch2, oe_n2;
  logic [0:0]  row2;
  logic        busy2, done2_pulse;

  led_panel_scanner #(.COLS(4), .ROWS(2), .BITS(2), .CLK_DIV(3), .BASE_TICKS(5)) dut2 (
    .CLOCK_50(clk), .reset(reset2), .enable(enable2),
    .fb_rd(fb_rd2), .fb_addr(fb_addr2), .fb_data(fb_data2),
    .panel_r(r2), .panel_g(g2), .panel_b(b2),
    .panel_sclk(sclk2), .panel_latch(latch2), .panel_oe_n(oe_n2),
    .panel_row(row2), .busy(busy2), .frame_done(done2_pulse)
  );

  always @(posedge clk) fb_data2 <= 6'($urandom);

  bit         mon2_en = 1'b0;
  bit         done2 = 1'b0;
  int         frames2 = 0;
  int         last_done2 = -1;
  int         oe_run2 = 0;
  bit         plane2 = 1'b0;
  logic [0:0] row2_prev = '0;

  always @(negedge clk) begin
    if (mon2_en) begin
      chk("inv2_latch_sclk", int'(latch2 & sclk2), 0);
      if (!oe_n2) chk("inv2_oe_only_display", int'({sclk2, latch2, fb_rd2}), 0);
      if (row2 != row2_prev) chk("inv2_row_change_blanked", int'(oe_n2), 1);
      if (!oe_n2) oe_run2++;
      else if (oe_run2 > 0) begin
        chk("inv2_oe_low_len", oe_run2, plane2 ? 10 : 5);
        plane2  = ~plane2;
        oe_run2 = 0;
      end
      if (done2_pulse) begin
        if (last_done2 >= 0) chk("inv2_frame_period", cyc - last_done2, 146);
        last_done2 = cyc;
        frames2++;
      end
    end
    row2_prev = row2;
  end

  initial begin
    int n;
    reset2 = 1'b1;
    enable2 = 1'b0;
    repeat (3) @(negedge clk);
    reset2  = 1'b0;
    enable2 = 1'b1;
    mon2_en = 1'b1;
    n = 0;
    while (frames2 < 10 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    enable2 = 1'b0;
    mon2_en = 1'b0;
    done2   = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int base;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Idle with enable low: any fetch would be flagged by the monitor
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_oe_n", int'(panel_oe_n), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_fb_rd", int'(fb_rd), 0);
    chk("idle_frame_done", int'(frame_done), 0);

    // Two back-to-back frames; enable dropped at cycle 20 of the second one
    enable = 1'b1;
    base   = cyc + 1;
    push_frame(base);
    push_frame(base + 64);
    while (cyc < base + 64 + 20) @(negedge clk);
    enable = 1'b0;
    while (cyc < base + 128) @(negedge clk);
    chk("post_frame_busy", int'(busy), 0);
    chk("post_frame_oe_n", int'(panel_oe_n), 1);
    chk("post_frame_fb_rd", int'(fb_rd), 0);
    repeat (10) @(negedge clk);
    check_drained();

    // Reset while row 1 is being displayed
    mon_en = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!(!panel_oe_n && panel_row == 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_row1_display", int'(n < 300), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");

    reset  = 1'b0;
    mon_en = 1'b1;
    base   = cyc + 1;
    push_frame(base);
    @(negedge clk);
    enable = 1'b0;
    while (cyc < base + 70) @(negedge clk);
    chk("restart_busy", int'(busy), 0);
    check_drained();

    n = 0;
    while (!done2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("inv2_frames", frames2, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
